tank_motion_ctrl: RTL and testbench

- Per-player tank movement and fire controller; parametrised successor of the single-ball keyboard mover.
- Sits between the USB keycode register and the sprite/collision logic; one instance per player, each with its own key map.
- Adds four-way facing, clamped screen-edge stops, external maze-wall blocking, a death/respawn FSM and a rate-limited fire pulse with ammo counting.
- Motion applies in the same frame it is decoded; there is no stale-motion lag.

---
 rtl/tank_motion_if.sv | 33 +++
 rtl/tank_motion_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_tank_motion_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/tank_motion_if.sv
// Signal bundle between the keycode/sprite fabric and one tank_motion_ctrl instance.
// The slave modport is the controller's view; master is the driver/observer side.
interface tank_motion_if #(
  parameter int COORD_W = 10,
  parameter int AMMO_W  = 3
);
  logic [31:0]        keycode;
  logic               wall_up;
  logic               wall_down;
  logic               wall_left;
  logic               wall_right;
  logic               hit;
  logic               respawn;
  logic               shot_done;
  logic [COORD_W-1:0] PosX;
  logic [COORD_W-1:0] PosY;
  logic [COORD_W-1:0] Size;
  logic [1:0]         Dir;
  logic               Moving;
  logic               Fire;
  logic [AMMO_W-1:0]  Ammo;
  logic               Alive;

  modport slave (
    input  keycode, wall_up, wall_down, wall_left, wall_right, hit, respawn, shot_done,
    output PosX, PosY, Size, Dir, Moving, Fire, Ammo, Alive
  );

  modport master (
    output keycode, wall_up, wall_down, wall_left, wall_right, hit, respawn, shot_done,
    input  PosX, PosY, Size, Dir, Moving, Fire, Ammo, Alive
  );
endinterface

// File: rtl/tank_motion_ctrl.sv
// Per-player tank mover: keycode decode, wall/edge-limited motion, death/respawn FSM
// and a cooldown-limited fire pulse with ammo accounting. Every output is registered.
module tank_motion_ctrl #(
  parameter int         COORD_W       = 10,
  parameter int         X_START       = 320,
  parameter int         Y_START       = 240,
  parameter int         X_MIN         = 0,
  parameter int         X_MAX         = 639,
  parameter int         Y_MIN         = 0,
  parameter int         Y_MAX         = 479,
  parameter int         STEP          = 1,
  parameter int         SIZE          = 10,
  parameter logic [7:0] KEY_UP        = 8'h1A,
  parameter logic [7:0] KEY_DOWN      = 8'h16,
  parameter logic [7:0] KEY_LEFT      = 8'h04,
  parameter logic [7:0] KEY_RIGHT     = 8'h07,
  parameter logic [7:0] KEY_FIRE      = 8'h2C,
  parameter int         FIRE_COOLDOWN = 15,
  parameter int         MAX_AMMO      = 5
) (
  input  logic          frame_clk,
  input  logic          Reset,
  tank_motion_if.slave  tank
);

  localparam int W1     = COORD_W + 1;
  localparam int AMMO_W = $clog2(MAX_AMMO + 1);
  localparam int CD_W   = $clog2(FIRE_COOLDOWN + 1);

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [COORD_W-1:0] STEP_C  = COORD_W'(STEP);
  localparam logic [COORD_W-1:0] X_RST   = COORD_W'(X_START);
  localparam logic [COORD_W-1:0] Y_RST   = COORD_W'(Y_START);
  localparam logic [COORD_W-1:0] X_LEFT  = COORD_W'(X_MIN + SIZE);
  localparam logic [COORD_W-1:0] X_RIGHT = COORD_W'(X_MAX - SIZE);
  localparam logic [COORD_W-1:0] Y_TOP   = COORD_W'(Y_MIN + SIZE);
  localparam logic [COORD_W-1:0] Y_BOT   = COORD_W'(Y_MAX - SIZE);
  localparam logic [W1-1:0]      X_LO    = W1'(X_MIN + SIZE + STEP);
  localparam logic [W1-1:0]      Y_LO    = W1'(Y_MIN + SIZE + STEP);
  localparam logic [W1-1:0]      REACH   = W1'(SIZE + STEP);
  localparam logic [W1-1:0]      X_HI    = W1'(X_MAX);
  localparam logic [W1-1:0]      Y_HI    = W1'(Y_MAX);
  localparam logic [AMMO_W-1:0]  AMMO_FULL = AMMO_W'(MAX_AMMO);

  typedef enum logic [1:0] {IDLE, MOVE, BLOCKED, DEAD} state_e;

  state_e              state_q, state_d;
  logic [COORD_W-1:0]  posX_q, posX_d, posY_q, posY_d;
  logic [1:0]          dir_q, dir_d;
  logic                moving_q, moving_d, fire_q, fire_d, firePrev_q, firePrev_d;
  logic [AMMO_W-1:0]   ammo_q, ammo_d;
  logic [CD_W-1:0]     cooldown_q, cooldown_d;

  logic       upKey, downKey, leftKey, rightKey, fireKey;
  logic       dirValid, wallSel, fireOk;
  logic [1:0] dirSel;

  function automatic logic keyHeld(input logic [31:0] kc, input logic [7:0] k);
    return (kc[7:0] == k) || (kc[15:8] == k) || (kc[23:16] == k) || (kc[31:24] == k);
  endfunction

  assign upKey    = keyHeld(tank.keycode, KEY_UP);
  assign downKey  = keyHeld(tank.keycode, KEY_DOWN);
  assign leftKey  = keyHeld(tank.keycode, KEY_LEFT);
  assign rightKey = keyHeld(tank.keycode, KEY_RIGHT);
  assign fireKey  = keyHeld(tank.keycode, KEY_FIRE);
  assign dirValid = upKey | downKey | leftKey | rightKey;

  always_comb begin
    dirSel  = DIR_RIGHT;
    wallSel = tank.wall_right;
    if (upKey) begin
      dirSel  = DIR_UP;
      wallSel = tank.wall_up;
    end else if (downKey) begin
      dirSel  = DIR_DOWN;
      wallSel = tank.wall_down;
    end else if (leftKey) begin
      dirSel  = DIR_LEFT;
      wallSel = tank.wall_left;
    end
  end

  assign fireOk = fireKey && !firePrev_q && (cooldown_q == '0) && (ammo_q != '0) && (state_q != DEAD);

  always_comb begin
    state_d    = state_q;
    posX_d     = posX_q;
    posY_d     = posY_q;
    dir_d      = dir_q;
    moving_d   = 1'b0;
    fire_d     = fireOk;
    firePrev_d = fireKey;
    ammo_d     = ammo_q;
    cooldown_d = (cooldown_q != '0) ? cooldown_q - CD_W'(1) : '0;

    if (fireOk) cooldown_d = CD_W'(FIRE_COOLDOWN);
    // A shot and a returning bullet on the same frame cancel out
    if (fireOk && !tank.shot_done)
      ammo_d = ammo_q - AMMO_W'(1);
    else if (!fireOk && tank.shot_done && ammo_q < AMMO_FULL)
      ammo_d = ammo_q + AMMO_W'(1);

    if (state_q == DEAD) begin
      if (tank.respawn) begin
        state_d    = IDLE;
        posX_d     = X_RST;
        posY_d     = Y_RST;
        dir_d      = DIR_UP;
        cooldown_d = '0;
        ammo_d     = AMMO_FULL;
      end
    end else if (tank.hit) begin
      state_d = DEAD;
    end else if (!dirValid) begin
      state_d = IDLE;
    end else begin
      dir_d   = dirSel;
      state_d = MOVE;
      if (wallSel) begin
        state_d = BLOCKED;
      end else begin
        // Edge tests run one bit wider so the +SIZE+STEP sum cannot wrap
        unique case (dirSel)
          DIR_UP:
            if ({1'b0, posY_q} < Y_LO) begin
              posY_d  = Y_TOP;
              state_d = BLOCKED;
            end else posY_d = posY_q - STEP_C;
          DIR_DOWN:
            if ({1'b0, posY_q} + REACH > Y_HI) begin
              posY_d  = Y_BOT;
              state_d = BLOCKED;
            end else posY_d = posY_q + STEP_C;
          DIR_LEFT:
            if ({1'b0, posX_q} < X_LO) begin
              posX_d  = X_LEFT;
              state_d = BLOCKED;
            end else posX_d = posX_q - STEP_C;
          default:
            if ({1'b0, posX_q} + REACH > X_HI) begin
              posX_d  = X_RIGHT;
              state_d = BLOCKED;
            end else posX_d = posX_q + STEP_C;
        endcase
      end
      moving_d = (posX_d != posX_q) || (posY_d != posY_q);
    end
  end

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      posX_q     <= X_RST;
      posY_q     <= Y_RST;
      dir_q      <= DIR_UP;
      moving_q   <= 1'b0;
      fire_q     <= 1'b0;
      firePrev_q <= 1'b0;
      ammo_q     <= AMMO_FULL;
      cooldown_q <= '0;
    end else begin
      state_q    <= state_d;
      posX_q     <= posX_d;
      posY_q     <= posY_d;
      dir_q      <= dir_d;
      moving_q   <= moving_d;
      fire_q     <= fire_d;
      firePrev_q <= firePrev_d;
      ammo_q     <= ammo_d;
      cooldown_q <= cooldown_d;
    end
  end

  assign tank.PosX   = posX_q;
  assign tank.PosY   = posY_q;
  assign tank.Size   = COORD_W'(SIZE);
  assign tank.Dir    = dir_q;
  assign tank.Moving = moving_q;
  assign tank.Fire   = fire_q;
  assign tank.Ammo   = ammo_q;
  assign tank.Alive  = (state_q != DEAD);

endmodule

// File: tb/tb_tank_motion_ctrl.sv
// Directed bench for tank_motion_ctrl: a vector table for single-frame behaviour and
// hand-written sequences for screen-edge clamping, fire cooldown/ammo and async reset.
module tb_tank_motion_ctrl;

  localparam logic [31:0] K_NONE  = 32'h0000_0000;
  localparam logic [31:0] K_UP    = 32'h0000_001A;
  localparam logic [31:0] K_DOWN  = 32'h0000_0016;
  localparam logic [31:0] K_LEFT  = 32'h0000_0004;
  localparam logic [31:0] K_RIGHT = 32'h0000_0007;
  localparam logic [31:0] K_FIRE  = 32'h0000_002C;

  typedef struct {
    logic [31:0] key;
    logic [3:0]  walls;
    logic        hit;
    logic        respawn;
    logic        shotDone;
    int          eX;
    int          eY;
    int          eDir;
    int          eMov;
    int          eFire;
    int          eAmmo;
    int          eAlive;
  } vec_t;

  logic clk;
  logic rstN;
  int   checks;
  int   failures;
  int   pulseCount;
  vec_t vecs [0:20];

  tank_motion_if #(.COORD_W(10), .AMMO_W(3)) bus ();

  tank_motion_ctrl dut (
    .frame_clk (clk),
    .Reset     (rstN),
    .tank      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkField(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input int eX, input int eY, input int eDir,
                             input int eMov, input int eFire, input int eAmmo, input int eAlive);
    checkField({tag, ".PosX"},   32'(bus.PosX),   eX);
    checkField({tag, ".PosY"},   32'(bus.PosY),   eY);
    checkField({tag, ".Dir"},    32'(bus.Dir),    eDir);
    checkField({tag, ".Moving"}, 32'(bus.Moving), eMov);
    checkField({tag, ".Fire"},   32'(bus.Fire),   eFire);
    checkField({tag, ".Ammo"},   32'(bus.Ammo),   eAmmo);
    checkField({tag, ".Alive"},  32'(bus.Alive),  eAlive);
  endtask

  task automatic applyStimulus(input logic [31:0] key, input logic [3:0] walls,
                               input logic hitV, input logic respawnV, input logic shotV);
    bus.keycode    = key;
    bus.wall_up    = walls[3];
    bus.wall_down  = walls[2];
    bus.wall_left  = walls[1];
    bus.wall_right = walls[0];
    bus.hit        = hitV;
    bus.respawn    = respawnV;
    bus.shot_done  = shotV;
    @(posedge clk);
    #1;
  endtask

  task automatic idleFrames(input int n);
    for (int i = 0; i < n; i++) applyStimulus(K_NONE, 4'b0000, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    vecs[0]  = '{K_RIGHT,      4'b0000, 1'b0, 1'b0, 1'b0, 321, 240, 3, 1, 0, 5, 1};
    vecs[1]  = '{K_RIGHT,      4'b0000, 1'b0, 1'b0, 1'b0, 322, 240, 3, 1, 0, 5, 1};
    vecs[2]  = '{K_RIGHT,      4'b0000, 1'b0, 1'b0, 1'b0, 323, 240, 3, 1, 0, 5, 1};
    vecs[3]  = '{K_RIGHT,      4'b0000, 1'b0, 1'b0, 1'b0, 324, 240, 3, 1, 0, 5, 1};
    vecs[4]  = '{K_RIGHT,      4'b0000, 1'b0, 1'b0, 1'b0, 325, 240, 3, 1, 0, 5, 1};
    vecs[5]  = '{K_NONE,       4'b0000, 1'b0, 1'b0, 1'b0, 325, 240, 3, 0, 0, 5, 1};
    vecs[6]  = '{K_UP,         4'b0000, 1'b0, 1'b0, 1'b0, 325, 239, 0, 1, 0, 5, 1};
    vecs[7]  = '{32'h0000_041A, 4'b0000, 1'b0, 1'b0, 1'b0, 325, 238, 0, 1, 0, 5, 1};
    vecs[8]  = '{K_RIGHT,      4'b0001, 1'b0, 1'b0, 1'b0, 325, 238, 3, 0, 0, 5, 1};
    vecs[9]  = '{K_RIGHT,      4'b0000, 1'b0, 1'b0, 1'b0, 326, 238, 3, 1, 0, 5, 1};
    vecs[10] = '{K_DOWN,       4'b0000, 1'b0, 1'b0, 1'b0, 326, 239, 1, 1, 0, 5, 1};
    vecs[11] = '{K_FIRE,       4'b0000, 1'b0, 1'b0, 1'b0, 326, 239, 1, 0, 1, 4, 1};
    vecs[12] = '{K_FIRE,       4'b0000, 1'b0, 1'b0, 1'b0, 326, 239, 1, 0, 0, 4, 1};
    vecs[13] = '{32'h0000_2C07, 4'b0000, 1'b0, 1'b0, 1'b0, 327, 239, 3, 1, 0, 4, 1};
    vecs[14] = '{K_NONE,       4'b0000, 1'b0, 1'b0, 1'b1, 327, 239, 3, 0, 0, 5, 1};
    vecs[15] = '{K_RIGHT,      4'b0000, 1'b1, 1'b0, 1'b0, 327, 239, 3, 0, 0, 5, 0};
    vecs[16] = '{K_RIGHT,      4'b0000, 1'b0, 1'b0, 1'b0, 327, 239, 3, 0, 0, 5, 0};
    vecs[17] = '{K_FIRE,       4'b0000, 1'b0, 1'b0, 1'b0, 327, 239, 3, 0, 0, 5, 0};
    vecs[18] = '{K_NONE,       4'b0000, 1'b0, 1'b1, 1'b0, 320, 240, 0, 0, 0, 5, 1};
    vecs[19] = '{K_UP,         4'b0000, 1'b0, 1'b1, 1'b1, 320, 239, 0, 1, 0, 5, 1};
    vecs[20] = '{K_DOWN,       4'b0100, 1'b0, 1'b0, 1'b0, 320, 239, 1, 0, 0, 5, 1};

    rstN          = 1'b0;
    bus.keycode    = K_NONE;
    bus.wall_up    = 1'b0;
    bus.wall_down  = 1'b0;
    bus.wall_left  = 1'b0;
    bus.wall_right = 1'b0;
    bus.hit        = 1'b0;
    bus.respawn    = 1'b0;
    bus.shot_done  = 1'b0;
    #12;
    rstN = 1'b1;
    #1;
    checkOutput("reset", 320, 240, 0, 0, 0, 5, 1);
    checkField("reset.Size", 32'(bus.Size), 10);

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].key, vecs[i].walls, vecs[i].hit, vecs[i].respawn, vecs[i].shotDone);
      checkOutput($sformatf("vec%0d", i), vecs[i].eX, vecs[i].eY, vecs[i].eDir,
                  vecs[i].eMov, vecs[i].eFire, vecs[i].eAmmo, vecs[i].eAlive);
    end

    // Left edge: 320 -> 12 by walking, then 11, 10, clamp at 10
    for (int i = 0; i < 308; i++) applyStimulus(K_LEFT, 4'b0000, 1'b0, 1'b0, 1'b0);
    checkField("leftWalk.PosX", 32'(bus.PosX), 12);
    applyStimulus(K_LEFT, 4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("left11", 11, 239, 2, 1, 0, 5, 1);
    applyStimulus(K_LEFT, 4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("left10", 10, 239, 2, 1, 0, 5, 1);
    applyStimulus(K_LEFT, 4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("leftClamp", 10, 239, 2, 0, 0, 5, 1);

    // Bottom edge: 239 -> 468, then 469, clamp at 469
    for (int i = 0; i < 229; i++) applyStimulus(K_DOWN, 4'b0000, 1'b0, 1'b0, 1'b0);
    checkField("downWalk.PosY", 32'(bus.PosY), 468);
    applyStimulus(K_DOWN, 4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("down469", 10, 469, 1, 1, 0, 5, 1);
    applyStimulus(K_DOWN, 4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("downClamp", 10, 469, 1, 0, 0, 5, 1);

    // Holding fire yields a single pulse
    pulseCount = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(K_FIRE, 4'b0000, 1'b0, 1'b0, 1'b0);
      if (bus.Fire === 1'b1) pulseCount++;
    end
    checkField("holdPulses", 32'(pulseCount), 1);
    checkField("holdAmmo", 32'(bus.Ammo), 4);

    idleFrames(1);
    applyStimulus(K_FIRE, 4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("refire", 10, 469, 1, 0, 1, 3, 1);
    idleFrames(4);
    applyStimulus(K_FIRE, 4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("earlyPress", 10, 469, 1, 0, 0, 3, 1);
    idleFrames(10);
    applyStimulus(K_FIRE, 4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("cooldownDone", 10, 469, 1, 0, 1, 2, 1);

    idleFrames(16);
    applyStimulus(K_FIRE, 4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("shot4", 10, 469, 1, 0, 1, 1, 1);
    idleFrames(16);
    applyStimulus(K_FIRE, 4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("shot5", 10, 469, 1, 0, 1, 0, 1);
    idleFrames(16);
    applyStimulus(K_FIRE, 4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("empty", 10, 469, 1, 0, 0, 0, 1);
    applyStimulus(K_NONE, 4'b0000, 1'b0, 1'b0, 1'b1);
    checkOutput("shotDone", 10, 469, 1, 0, 0, 1, 1);
    idleFrames(16);
    applyStimulus(K_FIRE, 4'b0000, 1'b0, 1'b0, 1'b1);
    checkOutput("fireAndDone", 10, 469, 1, 0, 1, 1, 1);

    // Reset asserted between edges must act immediately
    applyStimulus(K_RIGHT, 4'b0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(K_RIGHT, 4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("preReset", 12, 469, 3, 1, 0, 1, 1);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("asyncReset", 320, 240, 0, 0, 0, 5, 1);
    #3;
    rstN = 1'b1;
    applyStimulus(K_NONE, 4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("postReset", 320, 240, 0, 0, 0, 5, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
